multi_timer: RTL and testbench
==============================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 32, counter and timeout width in bits (8..32).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en_i  input  NUM_CH  per-channel run enable; low clears that channel's counter.
REQ-006 SHALL have port periodic_i  input  NUM_CH  per-channel mode: 1 = periodic auto-reload, 0 = one-shot.
REQ-007 SHALL have port timeout_i  input  NUM_CH*CNT_W  per-channel timeout in cycles; channel n occupies bits [n*CNT_W +: CNT_W].
REQ-008 SHALL have port irq_mask_i  input  NUM_CH  per-channel interrupt enable.
REQ-009 SHALL have port clear_i  input  NUM_CH  per-channel pending-flag clear, sampled each cycle.
REQ-010 SHALL have port busy_o  output  NUM_CH  channel is in RUN.
REQ-011 SHALL have port expire_o  output  NUM_CH  one-cycle registered expiry pulse per channel.
REQ-012 SHALL have port pending_o  output  NUM_CH  sticky per-channel expiry flag.
REQ-013 SHALL have port irq_o  output  1  OR of (pending_o AND irq_mask_i), combinational from registers and mask only.

Function
REQ-014 Each channel SHALL have a 3-state FSM: IDLE, RUN, DONE, plus counter cnt (CNT_W bits) and latched timeout tmo (CNT_W bits).
REQ-015 IDLE, en_i=1, timeout_i!=0: SHALL latch tmo<=timeout_i, set cnt<=1, and go to RUN.
REQ-016 IDLE, en_i=1, timeout_i==0: SHALL stay IDLE with cnt=0; a zero timeout never expires.
REQ-017 RUN, en_i=1, cnt!=tmo: SHALL increment cnt by 1.
REQ-018 RUN, en_i=1, cnt==tmo: SHALL assert expire_o for exactly the following cycle; periodic -> cnt<=1 and stay in RUN; one-shot -> go to DONE and hold cnt.
REQ-019 With en_i held high from the first sampling edge, expire_o SHALL first be high in the cycle after edge tmo, then every tmo cycles in periodic mode.
REQ-020 tmo==1 in periodic mode SHALL give expire_o high on every cycle after the first expiry.
REQ-021 Changes to timeout_i or periodic_i while in RUN or DONE: timeout_i SHALL be ignored until the next IDLE->RUN; periodic_i SHALL be evaluated at each expiry.
REQ-022 DONE SHALL hold until en_i=0. Restart SHALL require en_i low for at least one cycle.
REQ-023 en_i=0 in any state SHALL return to IDLE with cnt<=0 on the next edge and SHALL suppress any expiry that would occur on that edge. pending_o SHALL be unaffected.
REQ-024 pending_o[n] SHALL be set on the edge that raises expire_o[n], and cleared on an edge where clear_i[n]=1; simultaneous set and clear SHALL leave it set.
REQ-025 Channels SHALL be fully independent; simultaneous expiries on several channels SHALL each be reported in the same cycle.
REQ-026 busy_o[n] SHALL be 1 exactly when channel n is in RUN.
REQ-027 cnt SHALL never exceed tmo, so no wrap-around is possible; tmo = 2^CNT_W-1 SHALL be valid.

Reset
REQ-028 rst_i=1 at a clock edge SHALL force every channel to IDLE, with cnt=0, tmo=0, busy_o=0, expire_o=0, pending_o=0, and therefore irq_o=0 whenever pending_o=0. rst_i SHALL have priority over all other inputs.
REQ-029 Reset asserted mid-count SHALL discard the count; after release, counting SHALL restart from REQ-015 only if en_i=1.

Verification
REQ-030 Ch0 one-shot, timeout=5, en held high from edge 1: expire_o[0] high only after edge 5; pending_o[0]=1; with irq_mask_i[0]=1, irq_o=1; busy_o[0]=0 from edge 5 onward.
REQ-031 Ch1 periodic, timeout=3, en high for 10 edges: expire_o[1] pulses after edges 3, 6 and 9, and no other expiry occurs.
REQ-032 Ch2 timeout=4, en drops after edge 3 then rises again: no expire_o; the count restarts and expiry comes 4 edges after re-enable. Changing timeout_i to 2 mid-run has no effect.
REQ-033 Expiry and clear_i on the same edge: pending_o stays 1; clear_i next cycle -> 0; irq_o follows; a masked channel never raises irq_o.
REQ-034 rst_i during mid-count on all 4 channels: all outputs are 0 next cycle; timeout_i=0 with en_i=1 stays IDLE indefinitely.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: bank of independent one-shot/periodic timers with sticky pending flags and a masked IRQ
module multi_timer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       periodic_i,
    input  logic [NUM_CH*CNT_W-1:0] timeout_i,
    input  logic [NUM_CH-1:0]       irq_mask_i,
    input  logic [NUM_CH-1:0]       clear_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       expire_o,
    output logic [NUM_CH-1:0]       pending_o,
    output logic                    irq_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, tmo_q, tmo_in;
        logic             hit, busy, exp_q, pend_q;
        assign tmo_in = timeout_i[g*CNT_W +: CNT_W];
        // an expiry only counts while still enabled, so dropping en_i suppresses it
        assign hit = en_i[g] && state_q == RUN && cnt_q == tmo_q;
        // next-state: disable wins, zero timeout keeps the channel parked in IDLE
        always_comb begin
            state_d = state_q;
            if (!en_i[g])
                state_d = IDLE;
            else if (state_q == IDLE && tmo_in != '0)
                state_d = RUN;
            else if (hit && !periodic_i[g])
                state_d = DONE;
        end
        // state register
        always_ff @(posedge clk_i) begin
            if (rst_i)
                state_q <= IDLE;
            else
                state_q <= state_d;
        end
        // counter, latched timeout, expiry pulse and sticky pending flag (set beats clear)
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                tmo_q  <= '0;
                exp_q  <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                exp_q  <= hit;
                pend_q <= hit || (pend_q && !clear_i[g]);
                if (!en_i[g])
                    cnt_q <= '0;
                else if (state_q == IDLE && tmo_in != '0) begin
                    tmo_q <= tmo_in;
                    cnt_q <= CNT_W'(1);
                end else if (state_q == RUN && !hit)
                    cnt_q <= cnt_q + CNT_W'(1);
                else if (hit && periodic_i[g])
                    cnt_q <= CNT_W'(1);
            end
        end
        // outputs decoded from the state register
        always_comb busy = state_q == RUN;
        assign busy_o[g]    = busy;
        assign expire_o[g]  = exp_q;
        assign pending_o[g] = pend_q;
    end
    assign irq_o = |(pending_o & irq_mask_i);
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: randomized and directed checks of multi_timer against an edge-count reference model
module tb_multi_timer;
    localparam int N = 4;
    localparam int W = 8;
    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   en, per, mask, clr;
    logic [N*W-1:0] tmo_in;
    logic [N-1:0]   busy_o, expire_o, pending_o;
    logic           irq_o;
    int total = 0;
    int bad   = 0;
    // reference model: a running channel expires when tmo edges have elapsed since its anchor edge
    int       t = 0;
    bit       m_act [N];
    bit       m_done[N];
    int       m_anchor[N];
    int       m_tmo [N];
    logic [N-1:0] m_exp  = '0;
    logic [N-1:0] m_pend = '0;

    multi_timer #(.NUM_CH(N), .CNT_W(W)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .periodic_i(per), .timeout_i(tmo_in),
        .irq_mask_i(mask), .clear_i(clr), .busy_o(busy_o), .expire_o(expire_o),
        .pending_o(pending_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3*N:0] model_vec();
        logic [N-1:0] b;
        for (int c = 0; c < N; c++) b[c] = m_act[c];
        return {b, m_exp, m_pend, |(m_pend & mask)};
    endfunction

    task automatic tick();
        @(posedge clk);
        t++;
        for (int c = 0; c < N; c++) begin
            logic e;
            e = 1'b0;
            if (rst) begin
                m_act[c] = 0; m_done[c] = 0; m_pend[c] = 1'b0;
            end else begin
                if (!en[c]) begin
                    m_act[c] = 0; m_done[c] = 0;
                end else if (m_act[c]) begin
                    if (t - m_anchor[c] == m_tmo[c]) begin
                        e = 1'b1;
                        if (per[c]) m_anchor[c] = t;
                        else begin m_act[c] = 0; m_done[c] = 1; end
                    end
                end else if (!m_done[c] && tmo_in[c*W +: W] != '0) begin
                    m_act[c] = 1; m_anchor[c] = t; m_tmo[c] = int'(tmo_in[c*W +: W]);
                end
                m_pend[c] = e | (m_pend[c] & ~clr[c]);
            end
            m_exp[c] = e;
        end
        #1;
    endtask

    task automatic idle_all();
        en = '0; clr = '1;
        tick();
        clr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1; per = '1; mask = '1; clr = '0; tmo_in = {N{8'd3}};
        tick(); tick();
        total++; if (busy_o !== '0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        total++; if (expire_o !== '0)  begin bad++; $display("FAIL reset_expire got=%b want=0", expire_o); end
        total++; if (pending_o !== '0) begin bad++; $display("FAIL reset_pending got=%b want=0", pending_o); end
        total++; if (irq_o !== 1'b0)   begin bad++; $display("FAIL reset_irq got=%b want=0", irq_o); end
        rst = 1'b0;
    endtask

    task automatic test_oneshot();
        idle_all();
        tmo_in[0 +: W] = 8'd5; per[0] = 1'b0; mask = 4'b0001; en = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            tick();
            total++; if (expire_o[0] !== (i == 5)) begin bad++; $display("FAIL oneshot_expire i=%0d got=%b want=%b", i, expire_o[0], i == 5); end
            total++; if ({busy_o, expire_o, pending_o, irq_o} !== model_vec()) begin bad++; $display("FAIL oneshot_model i=%0d got=%h want=%h", i, {busy_o, expire_o, pending_o, irq_o}, model_vec()); end
        end
        total++; if (pending_o[0] !== 1'b1) begin bad++; $display("FAIL oneshot_pending got=%b want=1", pending_o[0]); end
        total++; if (irq_o !== 1'b1)        begin bad++; $display("FAIL oneshot_irq got=%b want=1", irq_o); end
        total++; if (busy_o[0] !== 1'b0)    begin bad++; $display("FAIL oneshot_busy got=%b want=0", busy_o[0]); end
    endtask

    task automatic test_periodic();
        int n;
        n = 0;
        idle_all();
        tmo_in[W +: W] = 8'd3; per[1] = 1'b1; en = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (expire_o !== '0) n++;
            total++; if (expire_o !== {2'b00, (i > 0 && i % 3 == 0), 1'b0}) begin bad++; $display("FAIL periodic_expire i=%0d got=%b", i, expire_o); end
            total++; if ({busy_o, expire_o, pending_o, irq_o} !== model_vec()) begin bad++; $display("FAIL periodic_model i=%0d got=%h want=%h", i, {busy_o, expire_o, pending_o, irq_o}, model_vec()); end
        end
        total++; if (n !== 3) begin bad++; $display("FAIL periodic_count got=%0d want=3", n); end
    endtask

    task automatic test_reenable();
        idle_all();
        tmo_in[2*W +: W] = 8'd4; per[2] = 1'b0; en = 4'b0100;
        for (int i = 0; i < 3; i++) tick();
        en = 4'b0000;
        tick();
        total++; if (expire_o[2] !== 1'b0 || busy_o[2] !== 1'b0) begin bad++; $display("FAIL reenable_drop got=%b%b want=00", expire_o[2], busy_o[2]); end
        en = 4'b0100;
        for (int j = 0; j < 7; j++) begin
            tick();
            if (j == 0) tmo_in[2*W +: W] = 8'd2;
            total++; if (expire_o[2] !== (j == 4)) begin bad++; $display("FAIL reenable_expire j=%0d got=%b want=%b", j, expire_o[2], j == 4); end
            total++; if ({busy_o, expire_o, pending_o, irq_o} !== model_vec()) begin bad++; $display("FAIL reenable_model j=%0d got=%h want=%h", j, {busy_o, expire_o, pending_o, irq_o}, model_vec()); end
        end
    endtask

    task automatic test_clear_collision();
        idle_all();
        tmo_in[0 +: W] = 8'd2; tmo_in[3*W +: W] = 8'd2; per = 4'b1001; mask = 4'b0001; en = 4'b1001;
        tick(); tick();
        clr = 4'b1001;
        tick();
        total++; if (expire_o !== 4'b1001)  begin bad++; $display("FAIL collide_expire got=%b want=1001", expire_o); end
        total++; if (pending_o !== 4'b1001) begin bad++; $display("FAIL collide_pending got=%b want=1001", pending_o); end
        total++; if (irq_o !== 1'b1)        begin bad++; $display("FAIL collide_irq got=%b want=1", irq_o); end
        en = 4'b0000;
        tick();
        total++; if (pending_o !== 4'b0000) begin bad++; $display("FAIL clear_pending got=%b want=0000", pending_o); end
        total++; if (irq_o !== 1'b0)        begin bad++; $display("FAIL clear_irq got=%b want=0", irq_o); end
        clr = '0; en = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        total++; if (pending_o[3] !== 1'b1 || irq_o !== 1'b0) begin bad++; $display("FAIL masked_irq got=%b%b want=10", pending_o[3], irq_o); end
    endtask

    task automatic test_reset_midcount();
        idle_all();
        tmo_in = {N{8'd10}}; per = 4'b0101; mask = '1; en = '1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; tmo_in = '0;
        tick();
        total++; if ({busy_o, expire_o, pending_o, irq_o} !== '0) begin bad++; $display("FAIL midreset got=%h want=0", {busy_o, expire_o, pending_o, irq_o}); end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++; if ({busy_o, expire_o, pending_o, irq_o} !== model_vec() || busy_o !== '0) begin bad++; $display("FAIL zero_tmo i=%0d got=%h want=%h", i, {busy_o, expire_o, pending_o, irq_o}, model_vec()); end
        end
    endtask

    task automatic test_max_tmo();
        int n;
        n = 0;
        idle_all();
        tmo_in[W +: W] = 8'hFF; per[1] = 1'b0; en = 4'b0010;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (expire_o[1]) begin
                n++;
                total++; if (i !== 255) begin bad++; $display("FAIL max_tmo_edge got=%0d want=255", i); end
            end
        end
        total++; if (n !== 1) begin bad++; $display("FAIL max_tmo_count got=%0d want=1", n); end
    endtask

    task automatic test_random();
        idle_all();
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            mask = N'($urandom);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 11) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 3) == 0) per[c] = 1'($urandom);
                tmo_in[c*W +: W] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
                clr[c] = ($urandom_range(0, 5) == 0);
            end
            tick();
            total++; if ({busy_o, expire_o, pending_o, irq_o} !== model_vec()) begin bad++; $display("FAIL random i=%0d got=%h want=%h", i, {busy_o, expire_o, pending_o, irq_o}, model_vec()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_reenable();
        test_clear_collision();
        test_reset_midcount();
        test_max_tmo();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
